// File: rtl/fetch_issue_unit.sv
// Front-end fetch/issue stage: holds the PC, fetches 12-bit instructions and issues
// opcode/operands over a valid/ready handshake. Jumps and halts are resolved locally.
module fetch_issue_unit #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [3:0] JMP_OP   = 4'hF,
  parameter logic [3:0] HLT_OP   = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic [11:0] imem_rdata,
  input  logic        imem_valid,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [3:0]  opcode,
  output logic [3:0]  operand_a,
  output logic [3:0]  operand_b,
  output logic [7:0]  pc_out,
  output logic        halted,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  state_t      state_q;
  logic [7:0]  pc_q;
  logic [3:0]  op_q, a_q, b_q;
  logic        req_q, ivld_q, halt_q, busy_q;

  logic [3:0]  f_op, f_a, f_b;
  assign f_op = imem_rdata[11:8];
  assign f_a  = imem_rdata[7:4];
  assign f_b  = imem_rdata[3:0];

  // Every output is a flop; the next value of each is set alongside the state transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      op_q    <= 4'h0;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      req_q   <= 1'b0;
      ivld_q  <= 1'b0;
      halt_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_valid) begin
            if (f_op == JMP_OP) begin
              // Request stays up; the new address goes out next cycle.
              pc_q <= {f_a, f_b};
            end else if (f_op == HLT_OP) begin
              state_q <= HALT;
              req_q   <= 1'b0;
              busy_q  <= 1'b0;
              halt_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
              req_q   <= 1'b0;
              ivld_q  <= 1'b1;
              op_q    <= f_op;
              a_q     <= f_a;
              b_q     <= f_b;
            end
          end
        end
        ISSUE: begin
          if (issue_ready) begin
            state_q <= FETCH;
            pc_q    <= pc_q + 8'd1;
            ivld_q  <= 1'b0;
            req_q   <= 1'b1;
          end
        end
        HALT: begin
          if (start) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            halt_q  <= 1'b0;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          ivld_q  <= 1'b0;
          halt_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign issue_valid = ivld_q;
  assign opcode      = op_q;
  assign operand_a   = a_q;
  assign operand_b   = b_q;
  assign halted      = halt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed bench for fetch_issue_unit: issue, backpressure, jump with memory wait,
// halt/restart, PC wrap and asynchronous reset mid-issue.
module tb_fetch_issue_unit;

  logic        clk, reset, start;
  logic        imem_req, imem_valid;
  logic [7:0]  imem_addr, pc_out;
  logic [11:0] imem_rdata;
  logic        issue_valid, issue_ready;
  logic [3:0]  opcode, operand_a, operand_b;
  logic        halted, busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] mem [256];
  int          mem_wait = 0;
  int          wcnt     = 0;

  fetch_issue_unit dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .pc_out(pc_out), .halted(halted), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then drive the memory response for the next edge.
  task automatic tick();
    logic had;
    had = imem_valid;
    @(posedge clk);
    #1;
    if (had) wcnt = 0;
    if (imem_req) begin
      if (wcnt >= mem_wait) begin
        imem_valid = 1'b1;
        imem_rdata = mem[imem_addr];
      end else begin
        imem_valid = 1'b0;
        wcnt++;
      end
    end else begin
      imem_valid = 1'b0;
      wcnt = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 12'h100;
    mem[8'h00] = 12'h123;
    mem[8'h01] = 12'hF3A;
    mem[8'h3A] = 12'h456;
    mem[8'h3B] = 12'hF05;
    mem[8'h05] = 12'h0AA;
    reset = 1'b0; start = 1'b0; issue_ready = 1'b0;
    imem_valid = 1'b0; imem_rdata = 12'h000;

    tick(); tick();
    chk("rst_req",   {11'd0, imem_req}, 12'h0);
    chk("rst_ivld",  {11'd0, issue_valid}, 12'h0);
    chk("rst_halt",  {11'd0, halted}, 12'h0);
    chk("rst_busy",  {11'd0, busy}, 12'h0);
    chk("rst_pc",    {4'd0, pc_out}, 12'h000);
    chk("rst_ops",   {opcode, operand_a, operand_b}, 12'h000);

    reset = 1'b1;
    issue_ready = 1'b1;
    tick();
    chk("idle_busy", {11'd0, busy}, 12'h0);
    chk("idle_req",  {11'd0, imem_req}, 12'h0);
    issue_ready = 1'b0;

    // Start; first fetch at 00 with zero wait
    start = 1'b1; tick(); start = 1'b0;
    chk("c1_req",  {11'd0, imem_req}, 12'h1);
    chk("c1_addr", {4'd0, imem_addr}, 12'h000);
    chk("c1_busy", {11'd0, busy}, 12'h1);
    issue_ready = 1'b1;
    tick();
    chk("c2_ivld", {11'd0, issue_valid}, 12'h1);
    chk("c2_ops",  {opcode, operand_a, operand_b}, 12'h123);
    chk("c2_req",  {11'd0, imem_req}, 12'h0);
    tick();
    chk("acc_pc",   {4'd0, pc_out}, 12'h001);
    chk("acc_ivld", {11'd0, issue_valid}, 12'h0);
    chk("acc_req",  {11'd0, imem_req}, 12'h1);

    // Jump at 01 -> 3A, target served after 3 wait cycles
    mem_wait = 3;
    tick();
    chk("jmp_pc",   {4'd0, pc_out}, 12'h03A);
    chk("jmp_ivld", {11'd0, issue_valid}, 12'h0);
    for (int i = 0; i < 3; i++) begin
      chk("wait_req",  {11'd0, imem_req}, 12'h1);
      chk("wait_addr", {4'd0, imem_addr}, 12'h03A);
      chk("wait_ivld", {11'd0, issue_valid}, 12'h0);
      tick();
    end

    // Backpressure on 456
    mem_wait = 0;
    issue_ready = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("bp_ivld", {11'd0, issue_valid}, 12'h1);
      chk("bp_ops",  {opcode, operand_a, operand_b}, 12'h456);
      chk("bp_pc",   {4'd0, pc_out}, 12'h03A);
      chk("bp_req",  {11'd0, imem_req}, 12'h0);
      if (i < 5) tick();
    end
    issue_ready = 1'b1;
    tick();
    chk("bp_rel_pc",   {4'd0, pc_out}, 12'h03B);
    chk("bp_rel_ivld", {11'd0, issue_valid}, 12'h0);
    tick();
    chk("bp_once_pc",  {4'd0, pc_out}, 12'h005);

    // Halt at 05
    tick();
    chk("hlt_halt", {11'd0, halted}, 12'h1);
    chk("hlt_pc",   {4'd0, pc_out}, 12'h005);
    chk("hlt_req",  {11'd0, imem_req}, 12'h0);
    chk("hlt_busy", {11'd0, busy}, 12'h0);
    tick();
    chk("hlt_hold", {11'd0, halted}, 12'h1);

    // Restart: 00 now jumps to FF, which holds 2AB
    mem[8'h00] = 12'hFFF;
    mem[8'hFF] = 12'h2AB;
    start = 1'b1; tick(); start = 1'b0;
    chk("rs_halt", {11'd0, halted}, 12'h0);
    chk("rs_pc",   {4'd0, pc_out}, 12'h000);
    chk("rs_req",  {11'd0, imem_req}, 12'h1);
    tick();
    chk("ff_addr", {4'd0, imem_addr}, 12'h0FF);
    mem[8'h00] = 12'hF10;
    mem[8'h10] = 12'h789;
    tick();
    chk("ff_ops",  {opcode, operand_a, operand_b}, 12'h2AB);
    tick();
    chk("wrap_pc", {4'd0, pc_out}, 12'h000);
    issue_ready = 1'b0;
    tick();
    chk("j10_pc",  {4'd0, pc_out}, 12'h010);
    tick();
    chk("i789_ivld", {11'd0, issue_valid}, 12'h1);
    chk("i789_ops",  {opcode, operand_a, operand_b}, 12'h789);

    // Async reset between edges
    #3 reset = 1'b0;
    #1;
    chk("ar_ivld", {11'd0, issue_valid}, 12'h0);
    chk("ar_pc",   {4'd0, pc_out}, 12'h000);
    chk("ar_ops",  {opcode, operand_a, operand_b}, 12'h000);
    chk("ar_busy", {11'd0, busy}, 12'h0);
    #1 reset = 1'b1;
    issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_idle_busy", {11'd0, busy}, 12'h0);
      chk("ar_idle_req",  {11'd0, imem_req}, 12'h0);
      chk("ar_idle_ivld", {11'd0, issue_valid}, 12'h0);
    end
    start = 1'b1; tick(); start = 1'b0;
    chk("ar_start_req",  {11'd0, imem_req}, 12'h1);
    chk("ar_start_addr", {4'd0, imem_addr}, 12'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_issue_unit.md
Name: fetch_issue_unit

Overview:
- Front-end stage directly upstream of the CPU datapath.
- Holds the program counter and fetches 12-bit instructions from an instruction-memory port.
- Splits each instruction into opcode / operand A / operand B and issues them downstream (opcode to ControlUnit, operands to ALU) over a valid/ready handshake.
- Resolves jump and halt instructions locally; these never reach the ALU.

Parameters:
RESET_PC, 8'h00, PC value loaded at reset and on restart from HALT
JMP_OP, 4'hF, opcode for absolute jump; target = {A,B}
HLT_OP, 4'h0, opcode for halt

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  one-cycle pulse; begins fetching from IDLE or HALT
imem_req  output  1  fetch request, held high until accepted
imem_addr  output  8  fetch address, equals pc_out whenever imem_req=1
imem_rdata  input  12  instruction {opcode[11:8], A[7:4], B[3:0]}
imem_valid  input  1  imem_rdata valid; counts only while imem_req=1
issue_valid  output  1  opcode/operand_a/operand_b valid for downstream
issue_ready  input  1  downstream accepts the issued instruction
opcode  output  4  issued opcode
operand_a  output  4  issued operand A
operand_b  output  4  issued operand B
pc_out  output  8  current PC
halted  output  1  high while in HALT
busy  output  1  high in FETCH or ISSUE

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE; pc_out = RESET_PC.
  - opcode, operand_a and operand_b = 0.
  - imem_req, issue_valid, halted and busy = 0.
- Reset asserted mid-fetch or mid-issue aborts immediately. No partial issue survives, and the next accept can occur only after deassert plus start.
- All outputs are registered.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: start=1 moves to FETCH next cycle. All other inputs are ignored.
- FETCH:
  - imem_req=1 and imem_addr=pc_out.
  - imem_valid=0: stay in FETCH and hold the request. Waiting has no limit.
  - imem_valid=1: sample imem_rdata on that edge, then decode:
    - opcode==JMP_OP: pc_out <= {A,B}; stay in FETCH. The new request is issued next cycle with no issue.
    - opcode==HLT_OP: go to HALT; pc_out is unchanged and points at the halt instruction.
    - Any other opcode: register opcode/operand_a/operand_b; issue_valid=1 next cycle; go to ISSUE.
  - Min fetch-to-issue latency: 1 cycle (imem_valid in cycle N, issue_valid in cycle N+1).
- ISSUE:
  - issue_valid=1. opcode and operands stay stable until the handshake completes.
  - issue_valid & issue_ready on an edge:
    - pc_out <= pc_out+1, modulo 256 (8'hFF wraps to 8'h00).
    - issue_valid drops to 0.
    - Go to FETCH.
  - Back-to-back throughput: one instruction per 2 cycles with zero memory wait.
  - issue_ready=0: hold everything indefinitely.
  - issue_ready is ignored outside ISSUE.
- HALT:
  - halted=1; imem_req=0.
  - start=1: pc_out <= RESET_PC; go to FETCH.
- start is ignored in FETCH and ISSUE.
- imem_valid is ignored when imem_req=0.
- A jump to its own address loops in FETCH forever. This is legal; start does not interrupt it, only reset does.
- busy = (state==FETCH) | (state==ISSUE).

Test Plan:
- Reset then start; memory returns 12'h123 at addr 00 with zero wait:
  - imem_req high cycle 1.
  - issue_valid cycle 2 with opcode=1, A=2, B=3.
  - With issue_ready=1, pc_out=01 on the next cycle.
- Backpressure: hold issue_ready=0 for 5 cycles after issue_valid:
  - Outputs stable; pc_out unchanged; imem_req=0.
  - Release: single accept; pc increments exactly once.
- Jump: instruction 12'hF3A at addr 01:
  - No issue_valid.
  - Next imem_addr=8'h3A.
  - Memory wait of 3 cycles keeps imem_req high and imem_addr=3A throughout.
- Halt and restart: instruction 12'h0xx at addr 05:
  - halted=1, pc_out=05, imem_req=0.
  - start pulse: pc_out=00, fetch resumes at 00.
- Wrap: jump to 8'hFF holding 12'h2AB; accept issue -> pc_out=8'h00.
- Async reset: assert reset=0 mid-ISSUE between clock edges:
  - issue_valid=0 and pc_out=RESET_PC immediately, without waiting for a clock edge.
  - After deassert: stays IDLE until start.
